// File: rtl/bw_io_ddr_pkg.sv
// Shared DDR I/O types and default sizes for the read/write pad-side repeaters.
package bw_io_ddr_pkg;

  localparam int unsigned DDR_DW_DFLT    = 16;
  localparam int unsigned DDR_BL_DFLT    = 4;
  localparam int unsigned DDR_DEPTH_DFLT = 4;

  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_t;

endpackage

// File: rtl/bw_io_ddr_rdata_rtmr_if.sv
// Core-side read-data stream: {fall,rise} word plus burst-last tag over valid/ready.
interface bw_io_ddr_rdata_rtmr_if
  import bw_io_ddr_pkg::*;
#(
  parameter int unsigned DW = DDR_DW_DFLT
);

  logic [2*DW-1:0] core_data;
  logic            core_last;
  logic            core_vld;
  logic            core_rdy;

  modport master (
    output core_data,
    output core_last,
    output core_vld,
    input  core_rdy
  );

  modport slave (
    input  core_data,
    input  core_last,
    input  core_vld,
    output core_rdy
  );

endinterface

// File: rtl/bw_io_ddr_rd_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is taken only when a pop frees a slot that cycle.
module bw_io_ddr_rd_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bw_io_ddr_rdata_rtmr.sv
// DDR read-data return path: retime pad beats, frame bursts, buffer and hand to core.
module bw_io_ddr_rdata_rtmr
  import bw_io_ddr_pkg::*;
#(
  parameter int unsigned DW    = DDR_DW_DFLT,
  parameter int unsigned DEPTH = DDR_DEPTH_DFLT,
  parameter int unsigned BL    = DDR_BL_DFLT
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic [DW-1:0]                 pad_rise,
  input  logic [DW-1:0]                 pad_fall,
  input  logic                          pad_vld,
  input  logic                          pad_first,
  input  logic                          err_clr,
  output logic                          stray_err,
  output logic                          trunc_err,
  output logic                          ovf_err,
  bw_io_ddr_rdata_rtmr_if.master        core
);

  localparam int unsigned WW    = 2*DW;
  localparam int unsigned CNT_W = $clog2(BL);
  localparam int unsigned FCW   = $clog2(DEPTH+1);

  logic            stg_vld_q, stg_vld_d;
  logic            stg_first_q, stg_first_d;
  logic [WW-1:0]   stg_data_q, stg_data_d;
  rd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            stray_q, stray_d;
  logic            trunc_q, trunc_d;
  logic            ovf_q, ovf_d;

  logic            wr_req;
  logic            wr_last;
  logic            stray_set;
  logic            trunc_set;
  logic            ovf_set;
  logic            pop;
  logic [WW:0]     fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [FCW-1:0]  fifo_count;

  // Stage 0: capture the pad beat as-is.
  always_comb begin
    stg_vld_d   = pad_vld;
    stg_first_d = pad_vld & pad_first;
    stg_data_d  = {pad_fall, pad_rise};
  end

  // Stage 1: burst framing; the beat counter advances even when the FIFO drops a beat.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_req    = 1'b0;
    wr_last   = 1'b0;
    stray_set = 1'b0;
    trunc_set = 1'b0;
    if (stg_vld_q) begin
      case (state_q)
        RD_IDLE: begin
          if (stg_first_q) begin
            wr_req  = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = RD_BURST;
          end else begin
            stray_set = 1'b1;
          end
        end
        RD_BURST: begin
          wr_req = 1'b1;
          if (stg_first_q) begin
            trunc_set = 1'b1;
            cnt_d     = CNT_W'(1);
          end else if (cnt_q == CNT_W'(BL-1)) begin
            wr_last = 1'b1;
            cnt_d   = '0;
            state_d = RD_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RD_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign pop     = core.core_vld & core.core_rdy;
  assign ovf_set = wr_req & fifo_full & ~pop;

  // Sticky errors: a set in the same cycle as err_clr wins.
  always_comb begin
    stray_d = stray_set | (stray_q & ~err_clr);
    trunc_d = trunc_set | (trunc_q & ~err_clr);
    ovf_d   = ovf_set   | (ovf_q   & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      stg_vld_q   <= 1'b0;
      stg_first_q <= 1'b0;
      stg_data_q  <= '0;
      state_q     <= RD_IDLE;
      cnt_q       <= '0;
      stray_q     <= 1'b0;
      trunc_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      stg_vld_q   <= stg_vld_d;
      stg_first_q <= stg_first_d;
      stg_data_q  <= stg_data_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stray_q     <= stray_d;
      trunc_q     <= trunc_d;
      ovf_q       <= ovf_d;
    end
  end

  bw_io_ddr_rd_fifo #(
    .W     (WW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .push      (wr_req),
    .push_data ({wr_last, stg_data_q}),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    assert (fifo_full == (fifo_count == FCW'(DEPTH)));
  end

  assign core.core_data = fifo_head[WW-1:0];
  assign core.core_last = fifo_head[WW];
  assign core.core_vld  = ~fifo_empty;

  assign stray_err = stray_q;
  assign trunc_err = trunc_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_bw_io_ddr_rdata_rtmr.sv
// Directed bench for the DDR read-data retimer: latency, framing, backpressure, errors, reset.
module tb_bw_io_ddr_rdata_rtmr;

  logic        clk;
  logic        rst_l;
  logic [15:0] pad_rise;
  logic [15:0] pad_fall;
  logic        pad_vld;
  logic        pad_first;
  logic        err_clr;
  logic        stray_err;
  logic        trunc_err;
  logic        ovf_err;

  int n_tests = 0;
  int n_fail  = 0;

  bw_io_ddr_rdata_rtmr_if #(.DW(16)) core_if ();

  bw_io_ddr_rdata_rtmr #(.DW(16), .DEPTH(4), .BL(4)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .pad_rise  (pad_rise),
    .pad_fall  (pad_fall),
    .pad_vld   (pad_vld),
    .pad_first (pad_first),
    .err_clr   (err_clr),
    .stray_err (stray_err),
    .trunc_err (trunc_err),
    .ovf_err   (ovf_err),
    .core      (core_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] r, input logic [15:0] f, input logic first);
    pad_rise  = r;
    pad_fall  = f;
    pad_vld   = 1'b1;
    pad_first = first;
  endtask

  task automatic idle();
    pad_vld   = 1'b0;
    pad_first = 1'b0;
    pad_rise  = '0;
    pad_fall  = '0;
  endtask

  task automatic clr_errs();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  // Back-to-back beats with core_rdy high; word c appears two cycles after it is driven.
  task automatic stream(input string tag, input logic [15:0] br, input logic [15:0] bf,
                        input int n, input logic [7:0] fm, input logic [7:0] lm);
    logic [15:0] er;
    logic [15:0] ef;
    for (int c = 0; c < n + 2; c++) begin
      if (c >= 2) begin
        er = br + 16'(c - 2);
        ef = bf + 16'(c - 2);
        chk({tag, "_vld"}, 64'(core_if.core_vld), 64'(1));
        chk({tag, "_dat"}, 64'(core_if.core_data), 64'({ef, er}));
        chk({tag, "_last"}, 64'(core_if.core_last), 64'(lm[c-2]));
      end else begin
        chk({tag, "_lat"}, 64'(core_if.core_vld), 64'(0));
      end
      if (c < n) drive(br + 16'(c), bf + 16'(c), fm[c]);
      else       idle();
      step();
    end
    chk({tag, "_drained"}, 64'(core_if.core_vld), 64'(0));
  endtask

  initial begin
    rst_l            = 1'b0;
    err_clr          = 1'b0;
    core_if.core_rdy = 1'b0;
    idle();
    step();
    step();
    chk("rst_vld",   64'(core_if.core_vld),  64'(0));
    chk("rst_data",  64'(core_if.core_data), 64'(0));
    chk("rst_last",  64'(core_if.core_last), 64'(0));
    chk("rst_stray", 64'(stray_err),         64'(0));
    chk("rst_trunc", 64'(trunc_err),         64'(0));
    chk("rst_ovf",   64'(ovf_err),           64'(0));
    rst_l = 1'b1;
    step();

    // 1: clean burst, two-cycle latency, last on 4th word
    core_if.core_rdy = 1'b1;
    stream("t1", 16'h0001, 16'hA001, 4, 8'h01, 8'h08);

    // 2: two bursts into a stalled FIFO, second burst dropped
    core_if.core_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(16'h0011 + 16'(i), 16'hB011 + 16'(i), i == 0);
      else       drive(16'h0021 + 16'(i - 4), 16'hB021 + 16'(i - 4), i == 4);
      step();
    end
    idle();
    step();
    step();
    chk("t2_ovf",   64'(ovf_err),   64'(1));
    chk("t2_trunc", 64'(trunc_err), 64'(0));
    chk("t2_stray", 64'(stray_err), 64'(0));
    chk("t2_hold",  64'(core_if.core_data), 64'(32'hB011_0011));
    core_if.core_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_vld",  64'(core_if.core_vld),  64'(1));
      chk("t2_dat",  64'(core_if.core_data), 64'({16'hB011 + 16'(i), 16'h0011 + 16'(i)}));
      chk("t2_last", 64'(core_if.core_last), 64'(i == 3));
      step();
    end
    chk("t2_empty", 64'(core_if.core_vld), 64'(0));
    clr_errs();
    chk("t2_ovf_clr", 64'(ovf_err), 64'(0));

    // 3: stray beat from IDLE
    drive(16'h0031, 16'hD031, 1'b0);
    step();
    idle();
    chk("t3_vld0", 64'(core_if.core_vld), 64'(0));
    step();
    chk("t3_vld1", 64'(core_if.core_vld), 64'(0));
    chk("t3_stray", 64'(stray_err), 64'(1));
    step();
    chk("t3_vld2", 64'(core_if.core_vld), 64'(0));
    clr_errs();
    chk("t3_stray_clr", 64'(stray_err), 64'(0));

    // 4: new first at beat 2 truncates the running burst
    stream("t4", 16'h0041, 16'hE041, 6, 8'h05, 8'h20);
    chk("t4_trunc", 64'(trunc_err), 64'(1));
    clr_errs();
    chk("t4_trunc_clr", 64'(trunc_err), 64'(0));

    // 5: push into a full FIFO while the core pops the same cycle
    core_if.core_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(16'h0051 + 16'(i), 16'hC051 + 16'(i), i == 0);
      step();
    end
    drive(16'h0061, 16'hC061, 1'b1);
    step();
    idle();
    core_if.core_rdy = 1'b1;
    chk("t5_full_head", 64'(core_if.core_data), 64'(32'hC051_0051));
    step();
    chk("t5_ovf", 64'(ovf_err), 64'(0));
    for (int i = 1; i < 4; i++) begin
      chk("t5_dat",  64'(core_if.core_data), 64'({16'hC051 + 16'(i), 16'h0051 + 16'(i)}));
      chk("t5_last", 64'(core_if.core_last), 64'(i == 3));
      step();
    end
    chk("t5_new_vld",  64'(core_if.core_vld),  64'(1));
    chk("t5_new_dat",  64'(core_if.core_data), 64'(32'hC061_0061));
    chk("t5_new_last", 64'(core_if.core_last), 64'(0));
    step();
    chk("t5_empty", 64'(core_if.core_vld), 64'(0));
    chk("t5_ovf_end", 64'(ovf_err), 64'(0));

    // 6: reset mid-burst discards buffered beats
    core_if.core_rdy = 1'b0;
    drive(16'h0071, 16'hF071, 1'b1);
    step();
    drive(16'h0072, 16'hF072, 1'b0);
    step();
    idle();
    step();
    step();
    chk("t6_pre_vld",   64'(core_if.core_vld), 64'(1));
    chk("t6_pre_trunc", 64'(trunc_err),        64'(1));
    rst_l = 1'b0;
    #1;
    chk("t6_rst_vld",   64'(core_if.core_vld),  64'(0));
    chk("t6_rst_data",  64'(core_if.core_data), 64'(0));
    chk("t6_rst_trunc", 64'(trunc_err),         64'(0));
    step();
    rst_l = 1'b1;
    step();
    drive(16'h0081, 16'h9081, 1'b0);
    step();
    idle();
    step();
    step();
    chk("t6_stray", 64'(stray_err),        64'(1));
    chk("t6_vld",   64'(core_if.core_vld), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
